// File: rtl/instruction_fetch_responder_pkg.sv
// Shared types for the instruction fetch responder: FSM states, fault kinds
// and the address fault decode used on request acceptance.
package instruction_fetch_responder_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, RESPOND, FAULT} FetchState_t;
  typedef enum logic [1:0] {NO_FAULT, MISALIGNED, OUT_OF_RANGE} FetchFault_t;

  // Wide enough for READ_LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  // Misalignment is checked first so it wins over an out-of-range address.
  function automatic FetchFault_t decode_fault(input logic [31:0] addr,
                                               input int unsigned words);
    if (addr[1:0] != 2'b00) return MISALIGNED;
    if ({2'b00, addr[31:2]} >= words) return OUT_OF_RANGE;
    return NO_FAULT;
  endfunction

endpackage

// File: rtl/fetch_last_word_buffer.sv
// Single-entry last-fetch buffer: one word address plus its data, with a
// combinational hit compare. Invalidate takes priority over a same-edge write.
module fetch_last_word_buffer #(
  parameter int unsigned AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          inv,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   rd_data
);

  logic          vld;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (inv) begin
      vld    <= 1'b0;
    end else if (wr_en) begin
      vld    <= 1'b1;
      addr_q <= wr_addr;
      data_q <= wr_data;
    end
  end

  assign hit     = vld && (addr_q == lookup_addr);
  assign rd_data = data_q;

endmodule

// File: rtl/instruction_fetch_responder.sv
// Instruction-port responder: faults bad addresses, serves same-PC re-fetches
// from the last-fetch buffer, otherwise reads the fixed-latency memory.
module instruction_fetch_responder
  import instruction_fetch_responder_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MEM_WORDS    = 16384,
  localparam int unsigned AW          = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetchRequest,
  input  logic [31:0]   instructionAddressToAccess,
  input  logic          cacheInvalidate,
  output logic          fetchReady,
  output logic [31:0]   instruction,
  output logic          instructionValid,
  output logic          misalignedFault,
  output logic          accessFault,
  output logic [AW-1:0] memAddress,
  output logic          memReadEnable,
  input  logic [31:0]   memReadData
);

  FetchState_t      state_q, state_d;
  FetchFault_t      req_fault, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_take, fill, kill_q;
  logic             buf_hit;
  logic [31:0]      buf_data;
  logic [AW-1:0]    req_word;

  assign req_fault  = decode_fault(instructionAddressToAccess, MEM_WORDS);
  assign req_word   = instructionAddressToAccess[AW+1:2];
  assign fetchReady = (state_q == IDLE);

  // A store seen at the request edge makes the buffered copy stale, so it
  // forces a memory read rather than a hit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fault_d  = NO_FAULT;
    hit_take = 1'b0;
    fill     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetchRequest) begin
          if (req_fault != NO_FAULT) begin
            state_d = FAULT;
            fault_d = req_fault;
          end else if (buf_hit && !cacheInvalidate) begin
            state_d  = RESPOND;
            hit_take = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
          fill    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND, FAULT: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      kill_q           <= 1'b0;
      instruction      <= '0;
      instructionValid <= 1'b0;
      misalignedFault  <= 1'b0;
      accessFault      <= 1'b0;
      memReadEnable    <= 1'b0;
      memAddress       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      instructionValid <= hit_take | fill;
      misalignedFault  <= (fault_d == MISALIGNED);
      accessFault      <= (fault_d == OUT_OF_RANGE);
      memReadEnable    <= (state_d == READ);
      if (state_d == READ) memAddress <= req_word;
      if (hit_take)  instruction <= buf_data;
      else if (fill) instruction <= memReadData;
      // Any invalidate while a read is in flight keeps that fill out of the buffer.
      if (state_d == READ)      kill_q <= 1'b0;
      else if (cacheInvalidate) kill_q <= 1'b1;
    end
  end

  fetch_last_word_buffer #(.AW(AW)) u_buf (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (fill & ~kill_q),
    .wr_addr     (memAddress),
    .wr_data     (memReadData),
    .inv         (cacheInvalidate),
    .lookup_addr (req_word),
    .hit         (buf_hit),
    .rd_data     (buf_data)
  );

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: directed cases then random fetches
// checked against a transaction-level model of the buffer and memory.
module tb_instruction_fetch_responder;

  localparam int RL = 2;
  localparam int MW = 16;
  localparam int AW = $clog2(MW);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetchRequest = 1'b0;
  logic [31:0]   instructionAddressToAccess = '0;
  logic          cacheInvalidate = 1'b0;
  logic          fetchReady, instructionValid, misalignedFault, accessFault, memReadEnable;
  logic [31:0]   instruction;
  logic [AW-1:0] memAddress;
  logic [31:0]   memReadData = '0;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic        buf_v = 1'b0;
  logic [29:0] buf_a = '0;
  logic [31:0] buf_d = '0;
  logic [31:0] last_instr = '0;

  instruction_fetch_responder #(.READ_LATENCY(RL), .MEM_WORDS(MW)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .fetchRequest               (fetchRequest),
    .instructionAddressToAccess (instructionAddressToAccess),
    .cacheInvalidate            (cacheInvalidate),
    .fetchReady                 (fetchReady),
    .instruction                (instruction),
    .instructionValid           (instructionValid),
    .misalignedFault            (misalignedFault),
    .accessFault                (accessFault),
    .memAddress                 (memAddress),
    .memReadEnable              (memReadEnable),
    .memReadData                (memReadData)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (w == 30'd4) return 32'h00500093;
    return {w[7:0], 8'hA5, 8'h13, w[7:0] ^ 8'h3C};
  endfunction

  // Backing memory: data is valid only at the edge RL edges after the
  // enable is sampled; every other cycle carries junk.
  int          left = 0;
  bit          armed = 1'b0;
  logic [29:0] mem_a = '0;
  always @(negedge clock) begin
    memReadData = 32'hBAD00000 | 32'($urandom_range(0, 65535));
    if (armed) begin
      left--;
      if (left == 0) begin
        memReadData = mem_word(mem_a);
        armed = 1'b0;
      end
    end
    if (memReadEnable) begin
      armed = 1'b1;
      left  = RL;
      mem_a = {{(30-AW){1'b0}}, memAddress};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_ready", fetchReady, 1);
    chk("idle_valid", instructionValid, 0);
    chk("idle_mis", misalignedFault, 0);
    chk("idle_acc", accessFault, 0);
    chk("idle_rden", memReadEnable, 0);
    chk("idle_instr", instruction, last_instr);
  endtask

  // One request from IDLE; inv_k>0 holds cacheInvalidate during that cycle.
  task automatic fetch(input logic [31:0] a, input int inv_k);
    int          kind, len;
    logic [29:0] w;
    logic [31:0] exp_d;
    w = a[31:2];
    if (a[1:0] != 2'b00)           kind = 2;
    else if (w >= 30'(MW))          kind = 3;
    else if (buf_v && buf_a == w)   kind = 0;
    else                            kind = 1;
    len   = (kind == 1) ? 2 + RL : 1;
    exp_d = (kind == 0) ? buf_d : mem_word(w);
    chk_idle();
    instructionAddressToAccess = a;
    fetchRequest    = 1'b1;
    cacheInvalidate = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clock);
      chk("busy_ready", fetchReady, 0);
      chk("valid", instructionValid, (kind < 2) && (k == len));
      chk("misaligned", misalignedFault, (kind == 2) && (k == len));
      chk("access", accessFault, (kind == 3) && (k == len));
      chk("rden", memReadEnable, (kind == 1) && (k == 1));
      if (kind == 1 && k == 1) chk("memaddr", 32'(memAddress), 32'(w));
      chk("instr", instruction, ((kind < 2) && (k == len)) ? exp_d : last_instr);
      // Junk requests while busy must be ignored.
      fetchRequest = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      instructionAddressToAccess = $urandom;
      cacheInvalidate = (k == inv_k);
    end
    if (kind < 2) last_instr = exp_d;
    if (kind == 1) begin
      buf_v = 1'b1; buf_a = w; buf_d = exp_d;
    end
    if (inv_k >= 1 && inv_k <= len) buf_v = 1'b0;
    @(negedge clock);
    cacheInvalidate = 1'b0;
  endtask

  task automatic idle_inv();
    cacheInvalidate = 1'b1;
    @(negedge clock);
    cacheInvalidate = 1'b0;
    buf_v = 1'b0;
    chk_idle();
  endtask

  task automatic check_reset_values();
    chk("rst_ready", fetchReady, 1);
    chk("rst_instr", instruction, 0);
    chk("rst_valid", instructionValid, 0);
    chk("rst_mis", misalignedFault, 0);
    chk("rst_acc", accessFault, 0);
    chk("rst_rden", memReadEnable, 0);
    chk("rst_memaddr", 32'(memAddress), 0);
  endtask

  // Reset lands on the edge ending the first WAIT cycle of a miss.
  task automatic reset_mid_read(input logic [31:0] a);
    instructionAddressToAccess = a;
    fetchRequest = 1'b1;
    @(negedge clock);
    chk("rstmid_rden", memReadEnable, 1);
    fetchRequest = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
    buf_v = 1'b0;
    last_instr = '0;
    @(negedge clock);
    chk("rstmid_late_valid", instructionValid, 0);
    chk("rstmid_late_instr", instruction, 0);
  endtask

  initial begin
    logic [31:0] a, last_a;
    int          r;
    last_a = 32'h10;
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    @(negedge clock);

    fetch(32'h00000010, 0);   // miss
    fetch(32'h00000010, 0);   // hit
    fetch(32'h00000020, 2);   // miss, invalidate during WAIT
    fetch(32'h00000020, 0);   // must miss again
    fetch(32'h00000006, 0);   // misaligned
    fetch(32'h0000003C, 0);   // last legal word
    fetch(32'h00000040, 0);   // first illegal word
    fetch(32'hFFFFFFFC, 0);   // top of address space
    fetch(32'hFFFFFFFF, 0);   // misaligned beats out-of-range
    fetch(32'h0000003C, 0);   // hit on last word
    idle_inv();
    fetch(32'h0000003C, 0);   // miss after idle invalidate
    fetch(32'h00000010, 0);   // fill word 4 for the reset case
    reset_mid_read(32'h00000024);
    fetch(32'h00000010, 0);   // buffer cleared by reset: misses

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      a = last_a;
      else if (r < 7) a = 32'($urandom_range(0, 17)) << 2;
      else if (r < 9) a = 32'($urandom_range(0, 80));
      else            a = $urandom;
      if ($urandom_range(0, 19) == 0) idle_inv();
      fetch(a, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0);
      last_a = a;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_responder.md
Name: instruction_fetch_responder

Overview:
- Responder on the memory controller's instruction port.
- Accepts the instruction address chosen by the core's fetch-address selection (next PC or current PC).
- Reads the word from a fixed-latency backing instruction memory and returns it with a one-cycle valid pulse.
- A single-entry last-fetch buffer lets a re-fetch of the same PC (CURRENT_PC case) return in one cycle with no memory access.
- Misaligned and out-of-range addresses are faulted without touching memory.

Parameters:
- READ_LATENCY, 2, cycles from the memReadEnable cycle to valid memReadData; legal range 1..15.
- MEM_WORDS, 16384, number of 32-bit words in instruction memory; valid byte addresses are 0 .. MEM_WORDS*4-1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetchRequest  in  1  request qualifier; sampled only when fetchReady=1.
- instructionAddressToAccess  in  32  byte address of the instruction.
- cacheInvalidate  in  1  clears the last-fetch buffer (asserted on stores to instruction memory).
- fetchReady  out  1  high only in IDLE.
- instruction  out  32  fetched instruction word; holds its value between responses.
- instructionValid  out  1  one-cycle pulse when instruction is updated.
- misalignedFault  out  1  one-cycle pulse.
- accessFault  out  1  one-cycle pulse for out-of-range addresses.
- memAddress  out  $clog2(MEM_WORDS)  word address to the backing memory.
- memReadEnable  out  1  one-cycle read strobe.
- memReadData  in  32  backing memory data.

Behaviour:
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, fetchReady=1 (registered from state).
  - instruction=0; instructionValid, misalignedFault, accessFault, memReadEnable all 0; memAddress=0.
  - Buffer invalid; latency counter 0.
- States: IDLE, READ, WAIT, RESPOND, FAULT.
- IDLE, with fetchRequest=1 sampled at edge T:
  - Address is captured.
  - If addr[1:0]!=0: go to FAULT, set misalignedFault. Misalignment takes priority over range.
  - Else if addr[31:2] >= MEM_WORDS: go to FAULT, set accessFault.
  - Else if buffer valid and bufferAddr==addr[31:2]: go to RESPOND, load instruction from the buffer (hit).
  - Else: go to READ (miss).
- READ (one cycle):
  - memReadEnable=1 and memAddress=captured word address.
  - Counter loads READ_LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter is 0, sample memReadData into instruction and into the buffer; go to RESPOND.
  - Data is sampled exactly READ_LATENCY edges after the READ edge.
  - memReadEnable=0 throughout.
- RESPOND: instructionValid=1 for one cycle, then IDLE.
- FAULT: the fault pulse is high for one cycle, then IDLE. instruction and the buffer are unchanged; instructionValid=0.
- Latency, with request sampled at edge T:
  - Hit: instructionValid in cycle T+1.
  - Fault: fault pulse in cycle T+1.
  - Miss: READ in T+1, instructionValid in cycle T+2+READ_LATENCY.
- Requests while fetchReady=0 are ignored: no queueing and no error.
- cacheInvalidate:
  - Clears buffer valid at the next edge, in any state.
  - If it coincides with the WAIT completion edge, or occurs at any point during READ/WAIT, the fill still delivers instruction but the buffer stays invalid. Invalidate wins.
- Buffer holds exactly one entry (word address plus data); every completed miss overwrites it.
- Reset mid-READ/WAIT:
  - Read is abandoned; late memReadData is ignored.
  - No instructionValid pulse; all outputs return to reset values the next cycle.
- Address boundaries: word address MEM_WORDS-1 is legal; MEM_WORDS is an access fault; 0xFFFFFFFC is an access fault.

Decomposition:
- JZJCoreFTypes gains:
  - FetchState_t enum: IDLE, READ, WAIT, RESPOND, FAULT.
  - FetchFault_t enum: NO_FAULT, MISALIGNED, OUT_OF_RANGE.
- Sub-module fetch_last_word_buffer: valid bit, word address and data registers, with a synchronous write and invalidate port (invalidate over write) and a combinational hit compare.
- FSM, counter and fault decode live in the top module.

Test Plan:
- Miss: reset, request 0x00000010, memory returns 0x00500093 with READ_LATENCY=2.
  -> memReadEnable with memAddress=4 in T+1; instructionValid with 0x00500093 in T+4; fetchReady low during T+1..T+4.
- Hit: repeat request 0x00000010 after the miss completes.
  -> instructionValid in T+1 with 0x00500093; memReadEnable stays 0.
- Invalidate during fill: cacheInvalidate pulsed during WAIT of a miss to 0x20, then re-request 0x20.
  -> the first fill delivers normally; the second request performs a full memory read.
- Misaligned: request 0x00000006.
  -> misalignedFault pulse in T+1; no memReadEnable; instruction unchanged.
- Out of range, MEM_WORDS=16: request 0x0000003C -> normal read at memAddress 15; request 0x00000040 -> accessFault in T+1.
- Reset asserted in the WAIT cycle of a miss.
  -> no instructionValid; next cycle all outputs at reset values, fetchReady=1, buffer invalid; a following request to the same address misses.
